// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding and load-use hazard detection.
// Latency: one cycle from ID capture to the ALU inputs; forwarding and load_use_stall are combinational.
// Backpressure: hold freezes the stage (operands re-captured); load_use_stall freezes IF/ID and inserts a bubble.
// Optional: define ID_EX_FWD_EN for EX/MEM and MEM/WB forwarding; otherwise every RAW hazard stalls.
module id_ex_stage #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               hold,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [2:0]         id_alu_ctrl,
   input  logic [DATA_W-1:0]  id_rs_data,
   input  logic [DATA_W-1:0]  id_rt_data,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic [4:0]         id_shamt,
   input  logic               id_alu_src,
   input  logic [RADDR_W-1:0] id_rs,
   input  logic [RADDR_W-1:0] id_rt,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic               id_uses_rt,
   input  logic               id_reg_dst,
   input  logic               id_reg_write,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic               id_mem_to_reg,
   input  logic               exmem_reg_write,
   input  logic [RADDR_W-1:0] exmem_rd,
   input  logic [DATA_W-1:0]  exmem_result,
   input  logic               memwb_reg_write,
   input  logic [RADDR_W-1:0] memwb_rd,
   input  logic [DATA_W-1:0]  memwb_result,
   output logic               load_use_stall,
   output logic               ex_valid,
   output logic [2:0]         alu_ctrl,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [4:0]         alu_shamt,
   output logic [DATA_W-1:0]  ex_store_data,
   output logic [RADDR_W-1:0] ex_wr_reg,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic               ex_mem_to_reg
);

   logic [DATA_W-1:0]  rs_data_q;
   logic [DATA_W-1:0]  rt_data_q;
   logic [DATA_W-1:0]  imm_q;
   logic [RADDR_W-1:0] rs_q;
   logic [RADDR_W-1:0] rt_q;
   logic               alu_src_q;
   logic [DATA_W-1:0]  fwd_rs;
   logic [DATA_W-1:0]  fwd_rt;
   logic               load_bubble;

`ifdef ID_EX_FWD_EN
   logic rs_exmem_hit, rs_memwb_hit, rt_exmem_hit, rt_memwb_hit;
   logic rs_load_hit, rt_load_hit;

   // Register 0 is hardwired to zero, so a match on it is never a real dependency.
   assign rs_exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q);
   assign rs_memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q);
   assign rt_exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q);
   assign rt_memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q);

   // Operand select: the younger producer (EX/MEM) wins over MEM/WB, then the captured data.
   always_comb begin
      fwd_rs = rs_data_q;
      fwd_rt = rt_data_q;
      if (rs_exmem_hit)      fwd_rs = exmem_result;
      else if (rs_memwb_hit) fwd_rs = memwb_result;
      if (rt_exmem_hit)      fwd_rt = exmem_result;
      else if (rt_memwb_hit) fwd_rt = memwb_result;
   end

   // Only a load in EX cannot be forwarded in time; everything else is covered by the muxes above.
   assign rs_load_hit    = (ex_wr_reg == id_rs);
   assign rt_load_hit    = id_uses_rt && (ex_wr_reg == id_rt);
   assign load_use_stall = ex_valid && ex_mem_read && (ex_wr_reg != '0) &&
                           (rs_load_hit || rt_load_hit) && id_valid;
`else
   logic rs_raw, rt_raw;
   logic unused_fwd_data;

   // Without forwarding the captured register-file data goes straight to the ALU.
   assign fwd_rs = rs_data_q;
   assign fwd_rt = rt_data_q;
   assign unused_fwd_data = ^{exmem_result, memwb_result};

   // Any in-flight writer of a source register (EX, EX/MEM or MEM/WB) must retire first.
   assign rs_raw = (id_rs != '0) &&
                   ((ex_valid && ex_reg_write && (ex_wr_reg == id_rs)) ||
                    (exmem_reg_write && (exmem_rd == id_rs)) ||
                    (memwb_reg_write && (memwb_rd == id_rs)));
   assign rt_raw = id_uses_rt && (id_rt != '0) &&
                   ((ex_valid && ex_reg_write && (ex_wr_reg == id_rt)) ||
                    (exmem_reg_write && (exmem_rd == id_rt)) ||
                    (memwb_reg_write && (memwb_rd == id_rt)));
   assign load_use_stall = id_valid && (rs_raw || rt_raw);
`endif

   assign alu_a         = fwd_rs;
   assign alu_b         = alu_src_q ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;

   // Reset and flush always empty the stage; a stall or an empty ID slot only does so when not holding.
   assign load_bubble = !rst_n || flush || (!hold && (load_use_stall || !id_valid));

   // Stage register: bubble, hold (re-capturing forwarded operands so they outlive their producers), or load.
   always_ff @(posedge clk) begin
      if (load_bubble) begin
         ex_valid      <= 1'b0;
         alu_ctrl      <= '0;
         rs_data_q     <= '0;
         rt_data_q     <= '0;
         imm_q         <= '0;
         alu_shamt     <= '0;
         alu_src_q     <= 1'b0;
         rs_q          <= '0;
         rt_q          <= '0;
         ex_wr_reg     <= '0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
      end else if (hold) begin
         rs_data_q <= fwd_rs;
         rt_data_q <= fwd_rt;
      end else begin
         ex_valid      <= 1'b1;
         alu_ctrl      <= id_alu_ctrl;
         rs_data_q     <= id_rs_data;
         rt_data_q     <= id_rt_data;
         imm_q         <= id_imm;
         alu_shamt     <= id_shamt;
         alu_src_q     <= id_alu_src;
         rs_q          <= id_rs;
         rt_q          <= id_rt;
         ex_wr_reg     <= id_reg_dst ? id_rd : id_rt;
         ex_reg_write  <= id_reg_write;
         ex_mem_read   <= id_mem_read;
         ex_mem_write  <= id_mem_write;
         ex_mem_to_reg <= id_mem_to_reg;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table of ID instructions with hand-computed ALU-side results, plus
// hand-written sequences for forwarding, hazard widening, hold and reset.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, hold, flush, id_valid;
   logic [2:0]  id_alu_ctrl;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_shamt;
   logic        id_alu_src;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rt, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        load_use_stall, ex_valid;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [4:0]  alu_shamt, ex_wr_reg;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

   int applied = 0;
   int fails   = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
      .id_alu_ctrl(id_alu_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_src(id_alu_src),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
      .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .load_use_stall(load_use_stall), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .ex_store_data(ex_store_data),
      .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
   );

   typedef struct {
      logic        valid;
      logic [2:0]  ctrl;
      logic [31:0] rs_data, rt_data, imm;
      logic [4:0]  shamt;
      logic        alu_src;
      logic [4:0]  rs, rt, rd;
      logic        uses_rt, reg_dst, rw, mr, mw, m2r, flush, hold;
   } in_t;

   typedef struct {
      logic        stall;
      logic        valid;
      logic [2:0]  ctrl;
      logic [31:0] a, b, store;
      logic [4:0]  shamt, wr;
      logic [3:0]  ctl;   // {reg_write, mem_read, mem_write, mem_to_reg}
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   localparam int NVEC = 17;
   vec_t tbl [NVEC];
   exp_t zero_e;
   in_t  ld;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_in(input in_t v);
      id_valid = v.valid;     id_alu_ctrl = v.ctrl;    id_rs_data = v.rs_data;
      id_rt_data = v.rt_data; id_imm = v.imm;          id_shamt = v.shamt;
      id_alu_src = v.alu_src; id_rs = v.rs;            id_rt = v.rt;
      id_rd = v.rd;           id_uses_rt = v.uses_rt;  id_reg_dst = v.reg_dst;
      id_reg_write = v.rw;    id_mem_read = v.mr;      id_mem_write = v.mw;
      id_mem_to_reg = v.m2r;  flush = v.flush;         hold = v.hold;
   endtask

   task automatic check_out(input exp_t e, input string tag);
      chk({tag, ".ex_valid"},  32'(ex_valid),  32'(e.valid));
      chk({tag, ".alu_ctrl"},  32'(alu_ctrl),  32'(e.ctrl));
      chk({tag, ".alu_a"},     alu_a,          e.a);
      chk({tag, ".alu_b"},     alu_b,          e.b);
      chk({tag, ".store"},     ex_store_data,  e.store);
      chk({tag, ".shamt"},     32'(alu_shamt), 32'(e.shamt));
      chk({tag, ".wr_reg"},    32'(ex_wr_reg), 32'(e.wr));
      chk({tag, ".ctl"},       32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'(e.ctl));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      zero_e = '{0, 0, 0, 0, 0, 0, 0, 0, 4'b0000};
      // ID inputs: valid ctrl rs_data rt_data imm shamt alu_src | rs rt rd | uses_rt reg_dst | rw mr mw m2r | flush hold
      // Expected: stall valid ctrl a b store shamt wr ctl
      tbl[0]  = '{'{1, 2, 24, 20984, 0, 0, 0, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0},
                  '{0, 1, 2, 24, 20984, 20984, 0, 3, 4'b1000}};
      tbl[1]  = '{'{1, 4, 100, 7, 32'hFFFFFFF0, 0, 1, 4, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0},
                  '{0, 1, 4, 100, 32'hFFFFFFF0, 7, 0, 9, 4'b1000}};
      tbl[2]  = '{'{1, 5, 0, 3, 0, 7, 0, 0, 10, 11, 1, 1, 1, 0, 0, 0, 0, 0},
                  '{0, 1, 5, 0, 3, 3, 7, 11, 4'b1000}};
      tbl[3]  = '{'{1, 2, 32'h1000, 32'hCAFEBABE, 8, 0, 1, 12, 13, 0, 1, 0, 0, 0, 1, 0, 0, 0},
                  '{0, 1, 2, 32'h1000, 8, 32'hCAFEBABE, 0, 13, 4'b0010}};
      tbl[4]  = '{'{1, 3, 5, 6, 0, 0, 0, 1, 2, 3, 1, 1, 1, 0, 0, 0, 1, 0},
                  '{0, 0, 0, 0, 0, 0, 0, 0, 4'b0000}};
      tbl[5]  = '{'{1, 2, 32'h2000, 0, 4, 0, 1, 14, 15, 0, 0, 0, 1, 1, 0, 1, 0, 0},
                  '{0, 1, 2, 32'h2000, 4, 0, 0, 15, 4'b1101}};
      tbl[6]  = '{'{1, 7, 1, 2, 3, 4, 0, 1, 2, 3, 1, 1, 1, 0, 1, 0, 0, 1},
                  '{0, 1, 2, 32'h2000, 4, 0, 0, 15, 4'b1101}};
      tbl[7]  = '{'{1, 1, 5, 6, 0, 0, 0, 3, 15, 16, 0, 1, 1, 0, 0, 0, 0, 0},
                  '{0, 1, 1, 5, 6, 6, 0, 16, 4'b1000}};
      tbl[8]  = '{'{1, 6, 9, 4, 0, 0, 0, 17, 18, 0, 1, 0, 1, 0, 0, 0, 0, 0},
                  '{0, 1, 6, 9, 4, 4, 0, 18, 4'b1000}};
      tbl[9]  = '{'{1, 2, 32'h40, 0, 0, 0, 1, 19, 5, 0, 0, 0, 1, 1, 0, 1, 0, 0},
                  '{0, 1, 2, 32'h40, 0, 0, 0, 5, 4'b1101}};
      tbl[10] = '{'{1, 2, 1, 2, 0, 0, 0, 5, 6, 7, 1, 1, 1, 0, 0, 0, 0, 0},
                  '{1, 0, 0, 0, 0, 0, 0, 0, 4'b0000}};
      tbl[11] = '{'{1, 2, 1, 2, 0, 0, 0, 5, 6, 7, 1, 1, 1, 0, 0, 0, 0, 0},
                  '{0, 1, 2, 1, 2, 2, 0, 7, 4'b1000}};
      tbl[12] = '{'{1, 2, 32'h44, 0, 0, 0, 1, 20, 5, 0, 0, 0, 1, 1, 0, 1, 0, 0},
                  '{0, 1, 2, 32'h44, 0, 0, 0, 5, 4'b1101}};
      tbl[13] = '{'{1, 0, 3, 4, 0, 0, 0, 6, 5, 8, 0, 1, 1, 0, 0, 0, 0, 0},
                  '{0, 1, 0, 3, 4, 4, 0, 8, 4'b1000}};
      tbl[14] = '{'{1, 2, 32'h48, 0, 0, 0, 1, 21, 5, 0, 0, 0, 1, 1, 0, 1, 0, 0},
                  '{0, 1, 2, 32'h48, 0, 0, 0, 5, 4'b1101}};
      tbl[15] = '{'{1, 2, 1, 2, 0, 0, 0, 6, 5, 9, 1, 1, 1, 0, 0, 0, 1, 1},
                  '{1, 0, 0, 0, 0, 0, 0, 0, 4'b0000}};
      tbl[16] = '{'{1, 2, 32'h10, 0, 32'hFFFFFFF0, 0, 1, 6, 22, 0, 0, 0, 1, 0, 0, 0, 0, 0},
                  '{0, 1, 2, 32'h10, 32'hFFFFFFF0, 0, 0, 22, 4'b1000}};
      ld = '{1, 2, 32'h55, 32'h66, 0, 0, 0, 8, 9, 10, 1, 1, 1, 0, 0, 0, 0, 0};

      // Reset held for two edges while ID offers a real instruction.
      exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
      rst_n = 0;
      apply_in(tbl[0].i);
      tick();
      tick();
      check_out(zero_e, "reset");
      chk("reset.stall", 32'(load_use_stall), 32'd0);
      rst_n = 1;

      // Table: drive, check the combinational stall, clock, check the stage contents.
      for (int k = 0; k < NVEC; k++) begin
         apply_in(tbl[k].i);
         #1;
         chk($sformatf("v%0d.stall", k), 32'(load_use_stall), 32'(tbl[k].e.stall));
         tick();
         check_out(tbl[k].e, $sformatf("v%0d", k));
      end

      // Capture an instruction with rs=8 (0x55) and rt=9 (0x66), then idle ID.
      apply_in(ld);
      tick();
      id_valid = 0;
`ifdef ID_EX_FWD_EN
      exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h139876AD;
      memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'h1;
      #1 chk("fwd.exmem_prio", alu_a, 32'h139876AD);
      exmem_reg_write = 0;
      #1 chk("fwd.memwb", alu_a, 32'h1);
      exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
      #1 chk("fwd.r0_never", alu_a, 32'h55);
      memwb_rd = 9; memwb_result = 32'h77;
      #1 chk("fwd.rt_b", alu_b, 32'h77);
      chk("fwd.rt_store", ex_store_data, 32'h77);
      exmem_rd = 9;
      #1 chk("fwd.rt_exmem", alu_b, 32'h139876AD);
      exmem_reg_write = 0; memwb_rd = 8; memwb_result = 32'hBADF00DE;
      hold = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("hold%0d.a", k), alu_a, 32'hBADF00DE);
      end
      memwb_reg_write = 0;
      #1;
      check_out('{0, 1, 2, 32'hBADF00DE, 32'h66, 32'h66, 0, 10, 4'b1000}, "hold_retired");
      hold = 0;
`else
      exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h139876AD;
      memwb_reg_write = 1; memwb_rd = 9; memwb_result = 32'h77;
      #1 chk("nofwd.a", alu_a, 32'h55);
      chk("nofwd.b", alu_b, 32'h66);
      chk("nofwd.store", ex_store_data, 32'h66);
      id_valid = 1; id_rs = 3; id_rt = 0; id_uses_rt = 0; exmem_rd = 3;
      #1 chk("raw.exmem", 32'(load_use_stall), 32'd1);
      exmem_reg_write = 0;
      #1 chk("raw.clear", 32'(load_use_stall), 32'd0);
      memwb_rd = 3;
      #1 chk("raw.memwb", 32'(load_use_stall), 32'd1);
      memwb_rd = 0; id_rs = 0;
      #1 chk("raw.r0", 32'(load_use_stall), 32'd0);
      id_uses_rt = 1; id_rt = 3; memwb_rd = 3;
      #1 chk("raw.rt", 32'(load_use_stall), 32'd1);
      memwb_reg_write = 0; id_uses_rt = 0; id_rs = 10;
      #1 chk("raw.ex", 32'(load_use_stall), 32'd1);
      tick();
      chk("raw.bubble", 32'(ex_valid), 32'd0);
      chk("raw.after", 32'(load_use_stall), 32'd0);
      apply_in(ld);
      tick();
      memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'hBADF00DE;
      hold = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("hold%0d.a", k), alu_a, 32'h55);
      end
      memwb_reg_write = 0;
      #1;
      check_out('{0, 1, 2, 32'h55, 32'h66, 32'h66, 0, 10, 4'b1000}, "hold_end");
      hold = 0;
`endif

      // Reset asserted during a hold still empties the stage.
      exmem_reg_write = 0; memwb_reg_write = 0;
      id_valid = 1; hold = 1; rst_n = 0;
      tick();
      check_out(zero_e, "reset_in_hold");
      rst_n = 1; hold = 0;

      $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
      $finish;
   end

endmodule
